// File: rtl/uart_rx_param.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_param
// Purpose  : Parametrised UART receiver. It has a two-flop input
//            synchroniser, start-bit glitch rejection, mid-bit sampling,
//            optional even/odd parity, one or two stop bits, and parity and
//            framing error flags. It produces one word per frame with a
//            single-cycle valid strobe.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   1          system clock, rising edge
//   rst        in   1          synchronous active-high reset
//   rx         in   1          asynchronous serial line, idle high
//   data_out   out  DATA_BITS  last received word, held until next frame
//   out_valid  out  1          one-cycle pulse when a frame completes
//   parity_err out  1          parity mismatch on the last frame
//   frame_err  out  1          a stop bit was sampled low on the last frame
//   busy       out  1          high whenever the receiver is not idle
// ============================================================================
module uart_rx_param #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 out_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 busy
);

  localparam int CNT_W  = $clog2(CLKS_PER_BIT);
  localparam int BIDX_W = $clog2(DATA_BITS + 1);
  localparam int HALF   = CLKS_PER_BIT / 2;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  sync1_q, rx_s_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [BIDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  perr_lat_q, perr_lat_d;
  logic                  ferr_lat_q, ferr_lat_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic                  perr_q, perr_d;
  logic                  ferr_q, ferr_d;
  logic                  valid_q, valid_d;

  logic                  w_mid;
  logic                  w_exp_par;
  logic                  w_ferr;

  // Sequential state: synchroniser, FSM and all datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      perr_lat_q <= 1'b0;
      ferr_lat_q <= 1'b0;
      data_q     <= '0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      sync1_q    <= rx;
      rx_s_q     <= sync1_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      perr_lat_q <= perr_lat_d;
      ferr_lat_q <= ferr_lat_d;
      data_q     <= data_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      valid_q    <= valid_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    perr_lat_d = perr_lat_q;
    ferr_lat_d = ferr_lat_q;
    data_d     = data_q;
    perr_d     = perr_q;
    ferr_d     = ferr_q;
    valid_d    = 1'b0;
    w_mid      = (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    w_exp_par  = (PARITY_MODE == 2) ? ~(^shift_q) : (^shift_q);
    w_ferr     = ferr_lat_q | ~rx_s_q;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s_q) begin
          state_d    = START;
          perr_lat_d = 1'b0;
          ferr_lat_d = 1'b0;
        end
      end

      // Re-check the line half a bit after the falling edge; a high level
      // there means the edge was a glitch.
      START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d   = '0;
          state_d = rx_s_q ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // cnt wraps at CLKS_PER_BIT-1, which lands on the middle of each bit
      // because the count started half a bit into the start bit.
      DATA: begin
        if (w_mid) begin
          cnt_d = '0;
          for (int i = 0; i < DATA_BITS; i++) begin
            if (bit_idx_q == BIDX_W'(i)) begin
              shift_d[i] = rx_s_q;
            end
          end
          if (bit_idx_q == BIDX_W'(DATA_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = (PARITY_MODE != 0) ? PARITY : STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      PARITY: begin
        if (w_mid) begin
          cnt_d      = '0;
          perr_lat_d = (rx_s_q != w_exp_par);
          state_d    = STOP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // bit_idx is reused here to count stop bits. Completion happens on the
      // mid-point of the last stop bit so a following start edge is not lost.
      STOP: begin
        if (w_mid) begin
          cnt_d      = '0;
          ferr_lat_d = w_ferr;
          if (bit_idx_q == BIDX_W'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            data_d    = shift_q;
            perr_d    = perr_lat_q;
            ferr_d    = w_ferr;
            valid_d   = 1'b1;
            state_d   = w_ferr ? WAIT_HIGH : IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // A low stop bit may be a break; wait for the line to recover before
      // looking for another start edge.
      WAIT_HIGH: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (rx_s_q) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        cnt_d     = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  assign data_out   = data_q;
  assign out_valid  = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign busy       = (state_q != IDLE);

endmodule
`default_nettype wire

// File: doc/uart_rx_param.md
Name: uart_rx_param

Overview:
Parametrised UART receiver and successor to the fixed 8-bit receiver. It adds configurable data width, parity mode, one or two stop bits and mid-bit sampling. It adds a two-flop input synchroniser, start-bit glitch rejection, and parity and framing error flags. It sits between the rx pad and the byte-consumer logic and outputs one word per frame with a single-cycle valid strobe.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; must be >= 4.
DATA_BITS, 8, data bits per frame, legal range 5..9, sent LSB first.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd.
STOP_BITS, 1, 1 or 2.

Ports:
clk  input  1  system clock; all logic on the rising edge.
rst  input  1  synchronous, active-high reset.
rx  input  1  asynchronous serial line, idle high.
data_out  output  DATA_BITS  last received word; held until the next completed frame.
out_valid  output  1  one-cycle pulse when a frame completes.
parity_err  output  1  parity mismatch on the last frame; held like data_out; always 0 when PARITY_MODE = 0.
frame_err  output  1  a stop bit was sampled low on the last frame; held like data_out.
busy  output  1  high in every state except IDLE.

Behaviour:
Clock and reset (already decided):
- One clock, clk.
- Reset rst is synchronous and active-high.

Reset:
- On rst, state goes to IDLE and bit/clock counters clear.
- data_out = 0, out_valid = 0, parity_err = 0, frame_err = 0, busy = 0.
- Synchroniser flops load 1.
- rst mid-frame abandons the frame. No out_valid is produced.

Input path:
- rx passes through two flops to give rx_s.
- All decisions below use rx_s, so latency from pin to rx_s is 2 cycles.

Counters:
- cnt is $clog2(CLKS_PER_BIT) bits wide. HALF = CLKS_PER_BIT/2, integer division.
- bit_idx is $clog2(DATA_BITS+1) bits wide.

States:
- IDLE: cnt = 0 and bit_idx = 0. When rx_s = 0, go to START.
- START: cnt increments each cycle. At cnt == HALF-1, test rx_s:
  - rx_s = 0: go to DATA with cnt = 0.
  - rx_s = 1: glitch; go to IDLE with no output.
- DATA: cnt counts 0..CLKS_PER_BIT-1. At cnt == CLKS_PER_BIT-1, this point being mid-bit:
  - Store rx_s into shift[bit_idx] and clear cnt.
  - If bit_idx == DATA_BITS-1, go to PARITY when PARITY_MODE != 0, otherwise to STOP.
  - Otherwise bit_idx increments.
- PARITY: sample at the same mid-bit point.
  - Expected bit = XOR(shift) for even mode, ~XOR(shift) for odd mode.
  - Latch the mismatch, then go to STOP.
- STOP: sample each stop bit at mid-bit.
  - Any low sample sets the frame_err latch.
  - After STOP_BITS samples, the completion cycle registers in the same clock edge:
    - data_out <= shift
    - parity_err and frame_err <= their latches
    - out_valid <= 1 for exactly one cycle
  - Next state: IDLE if frame_err is clear, otherwise WAIT_HIGH.
- WAIT_HIGH: break or line-fault recovery. Stay until rx_s = 1, then go to IDLE. No new frame can start in this state.
- Illegal state encodings return to IDLE.

Timing and latency:
- out_valid rises on the edge after the mid-point sample of the last stop bit, plus the 2-cycle synchroniser delay from the pin.
- Back-to-back frames: IDLE is re-entered at the middle of the stop bit. A start edge that follows immediately after the stop bit must be caught with no lost frame.

Error flags and width:
- Error latches clear on entry to START.
- out_valid is never asserted from START, DATA or PARITY.
- The shift register is DATA_BITS wide and there is no truncation. Bits are written by index, so the first received bit goes to data_out[0].

Test Plan:
- CLKS_PER_BIT=8, DATA_BITS=8, PARITY_MODE=1, STOP_BITS=1; send 0xA5 with parity bit 0 and stop bit 1 -> one out_valid pulse, data_out = 0xA5, parity_err = 0, frame_err = 0, busy low after the pulse.
- Same configuration; send 0xA5 with parity bit 1 -> data_out = 0xA5, parity_err = 1. Change to PARITY_MODE=2 and repeat -> parity_err = 0.
- Send 0x3C with stop bit 0, then hold rx low for 30 cycles, then raise it -> out_valid pulses with frame_err = 1. busy stays high until rx_s returns high. The next valid frame 0x01 gives frame_err = 0.
- rx low for 2 cycles (less than HALF), then high -> no out_valid; state back to IDLE within HALF+2 cycles.
- Back-to-back frames 0x00, 0xFF, 0x55 with no idle gap -> three out_valid pulses with the matching data.
- Assert rst for 1 cycle in the middle of bit 4 -> no out_valid and all outputs 0. A following frame with DATA_BITS=5, STOP_BITS=2, value 0x15 -> data_out = 5'h15.
